reaction_timer: RTL
===================

Name: reaction_timer

Overview:
- Downstream measurement stage of the lights-sequence FSM.
- Counts elapsed milliseconds from "lights out" (go) to the player's button press as a DIGITS-wide BCD value for the 7-segment display driver.
- Flags a false start (press before go) and counter saturation.
- Driven by the shared 1 ms tick pulse and the FSM's arm/go outputs.

Parameters:
- DIGITS, 4, number of BCD digits; full-scale value is 10^DIGITS - 1 (9999 at default).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- arm  input  1  single-cycle pulse: start a new measurement.
- go  input  1  level: lights out, timing may start.
- ms_tick  input  1  single-cycle pulse once per millisecond.
- btn  input  1  debounced player button, active high.
- clear  input  1  single-cycle pulse: return to idle, zero result.
- bcd  output  4*DIGITS  result; digit 0 (ms units) in bits [3:0].
- valid  output  1  high while a completed, legal measurement is held.
- false_start  output  1  high while a false-start result is held.
- overflow  output  1  high once the counter has saturated in the current measurement.
- busy  output  1  high in ARMED or COUNT.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset (rst sampled high at a clk edge):
  - state=IDLE.
  - bcd=0, valid=0, false_start=0, overflow=0, busy=0.
  - Internal btn_q=0.
  - rst overrides every other input.
- Press detection:
  - btn_q registers btn every cycle.
  - press = btn & ~btn_q (rising edge only).
  - Holding btn high produces exactly one press.
- clear: in any state, clear moves to IDLE and zeroes bcd and all flags next cycle. It has priority over arm, go, press and ms_tick.
- States (all outputs registered):
  - IDLE: holds bcd and flags. arm -> ARMED, with bcd, valid, false_start and overflow zeroed on the same edge.
  - ARMED: busy=1.
    - press -> FAULT, false_start=1.
    - else go=1 -> COUNT.
    - press and go in the same cycle -> FAULT (press wins).
    - ms_tick ignored.
  - COUNT: busy=1.
    - Each ms_tick increments bcd as a decimal counter: digit ripple-carry, each digit 0..9, carry into the next digit on 9->0.
    - At all-nines, further ticks leave bcd unchanged and set overflow=1.
    - press -> DONE, valid=1, busy=0. A tick in the same cycle as press is discarded; bcd freezes at its pre-edge value.
    - go deasserting in COUNT is ignored.
  - DONE: holds bcd, valid=1. arm -> ARMED (restart, fields zeroed).
  - FAULT: holds bcd=0, false_start=1. arm -> ARMED (restart, fields zeroed).
- arm is ignored in ARMED and COUNT.
- valid and false_start are never high together.
- Latency: press at edge N makes valid/false_start visible after edge N. First tick after entering COUNT yields bcd=0001.
- Never produces a non-BCD digit (A-F).

Test Plan:
- Reset/idle: rst for 2 cycles with btn=1, go=1 -> bcd=0, all flags 0, busy=0; release rst with btn held high -> no press detected.
- Normal run: arm, go high 3 cycles later, 347 ms_tick pulses, then btn rising -> valid=1, bcd=16'h0347, busy=0, false_start=0; result held 100 cycles until arm.
- Carry chain: 999 ticks then 1 more -> bcd goes 16'h0999 -> 16'h1000. Check 0009->0010 and 0099->0100 transitions en route.
- Saturation: 10005 ticks in COUNT -> bcd=16'h9999, overflow=1. Press -> valid=1, bcd stays 9999, overflow stays 1.
- False start: arm, btn rising before go -> false_start=1, valid=0, bcd=0; go later has no effect. Repeat with press and go in the same cycle -> FAULT.
- Simultaneous/priority:
  - ms_tick and press same cycle at bcd=0041 -> final 0041.
  - clear and arm same cycle in DONE -> IDLE, bcd=0.
  - arm pulsed mid-COUNT -> ignored, count continues.

Source files
------------

// File: rtl/reaction_timer.sv
// Reaction-time measurement stage: counts ms ticks from lights-out (go) to the
// player's button press as a saturating BCD value, and flags false starts.
module reaction_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                go,
  input  logic                ms_tick,
  input  logic                btn,
  input  logic                clear,
  output logic [4*DIGITS-1:0] bcd,
  output logic                valid,
  output logic                false_start,
  output logic                overflow,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, ARMED, COUNT, DONE, FAULT} state_t;

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t state;
  logic   btn_q;
  logic   press;

  assign press = btn & ~btn_q;

  // Decimal ripple-carry increment; each digit wraps 9->0 and carries upward.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic       carry;
    logic [3:0] d;
    bcd_inc = v;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = d + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  endfunction

  // NOTE: all state and outputs are registered with non-blocking assignments so
  // every branch reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      btn_q       <= 1'b0;
      bcd         <= '0;
      valid       <= 1'b0;
      false_start <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      btn_q <= btn;
      if (clear) begin
        state       <= IDLE;
        bcd         <= '0;
        valid       <= 1'b0;
        false_start <= 1'b0;
        overflow    <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE, FAULT: begin
            if (arm) begin
              state       <= ARMED;
              bcd         <= '0;
              valid       <= 1'b0;
              false_start <= 1'b0;
              overflow    <= 1'b0;
              busy        <= 1'b1;
            end
          end
          ARMED: begin
            // A press wins over a simultaneous go: that is still a false start.
            if (press) begin
              state       <= FAULT;
              false_start <= 1'b1;
              busy        <= 1'b0;
            end else if (go) begin
              state <= COUNT;
            end
          end
          COUNT: begin
            if (press) begin
              state <= DONE;
              valid <= 1'b1;
              busy  <= 1'b0;
            end else if (ms_tick) begin
              if (bcd == ALL_NINES) begin
                overflow <= 1'b1;
              end else begin
                bcd <= bcd_inc(bcd);
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
